reg_router: RTL
===============

Name: reg_router

Overview:
- Parametrised successor to the fixed per-peripheral register decoder between spi_slave and the peripheral blocks (gpo, led, fifo, tx_dac_fsm).
- Maps a contiguous window of NUM_CH register addresses onto NUM_CH peripheral channels using one-hot wr_en/rd_en strobes and a registered read-return path.
- New behaviour: burst transfers with address auto-increment, a fixed return value for unmapped addresses, and a saturating error counter.

Parameters:
- ADDR_W, 7, register address width (matches spi_slave addrsz).
- DATA_W, 8, payload width.
- NUM_CH, 16, number of mapped channels (1..2**ADDR_W).
- BASE_ADDR, 0, address of channel 0; channel i is at BASE_ADDR+i.
- AUTO_INC, 1, 1 = address increments after each data byte in a burst; 0 = address fixed.
- UNMAPPED_VAL, 8'hEE, tx_d value returned for an unmapped read.
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- reg_addr  in  ADDR_W  address from spi_slave.
- addr_dv  in  1  one-cycle pulse: reg_addr and rw_out valid.
- rw_out  in  1  1 = read, 0 = write.
- rx_d  in  DATA_W  received byte.
- rxdv  in  1  one-cycle pulse: rx_d valid.
- txn_end  in  1  one-cycle pulse at end of SPI frame (SSB rising, already synchronised).
- tx_d  out  DATA_W  read data to spi_slave.
- tx_en  out  1  one-cycle pulse: tx_d valid.
- wr_en  out  NUM_CH  one-hot write strobe.
- rd_en  out  NUM_CH  one-hot read strobe.
- data_to_periph  out  DATA_W  write data, shared by all channels.
- data_from_periph  in  NUM_CH*DATA_W  read data; channel i occupies bits [i*DATA_W +: DATA_W].
- err_cnt  out  ERR_W  count of unmapped accesses, saturating.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset: state IDLE. tx_d=0, tx_en=0, wr_en=0, rd_en=0, data_to_periph=0, err_cnt=0, latched address=0, latched rw=0.
- All outputs are registered.
- Address decode: mapped = (addr >= BASE_ADDR) && (addr - BASE_ADDR < NUM_CH); ch = addr - BASE_ADDR. Compare in ADDR_W+1 bits so the bound check cannot overflow.
- State IDLE: on addr_dv, latch reg_addr and rw_out. rw_out=1 goes to RD_STROBE; rw_out=0 goes to WR_WAIT.
- State WR_WAIT, on rxdv:
  - Mapped: next cycle wr_en[ch]=1 for one cycle, and data_to_periph=rx_d. Write latency is 1 cycle.
  - Unmapped: no strobe; err_cnt increments.
  - If AUTO_INC=1, the address increments modulo 2**ADDR_W.
  - State remains WR_WAIT.
- State RD_STROBE (1 cycle): drive rd_en[ch]=1 if mapped, else count an error. Next state RD_CAPTURE.
- State RD_CAPTURE (1 cycle): tx_d = mapped ? data_from_periph[ch] : UNMAPPED_VAL; tx_en=1. Next state RD_WAIT.
  - Read latency: addr_dv at cycle N gives rd_en at N+1 and tx_d/tx_en at N+2.
- State RD_WAIT, on rxdv (dummy byte of a read burst):
  - If AUTO_INC=1, address increments and the next state is RD_STROBE.
  - If AUTO_INC=0, the same address is re-read via RD_STROBE.
- Priority in any state: addr_dv > txn_end > rxdv.
  - addr_dv restarts the transaction from the new address.
  - A simultaneous rxdv is dropped, with no strobe and no error.
- txn_end in any state returns to IDLE. Any in-flight strobe already registered for that cycle still completes; no new strobe issues.
- rxdv in IDLE, RD_STROBE or RD_CAPTURE is ignored and does not count as an error.
- err_cnt saturates at all-ones. If err_clr and an error occur in the same cycle, err_clr wins and the result is 0.
- Asynchronous reset mid-burst aborts immediately; no further strobes issue.
- Only one wr_en/rd_en bit is high in any cycle; wr_en and rd_en are never high together.

Decomposition:
- reg_router_pkg holds:
  - typedef enum state_t {IDLE, WR_WAIT, RD_STROBE, RD_CAPTURE, RD_WAIT};
  - the default UNMAPPED_VAL constant;
  - a channel-index helper function.
- Sub-module reg_router_dec (combinational) takes addr, BASE_ADDR and NUM_CH and outputs mapped and ch. It is reused for the write and read paths.

Test Plan:
- Single write: BASE_ADDR=0x10, addr_dv with addr=0x13 and rw=0, then rxdv with rx_d=0xA5 -> one cycle later wr_en=16'h0008 and data_to_periph=0xA5 for exactly 1 cycle; err_cnt=0.
- Single read: data_from_periph ch2=0x5C, addr_dv with addr=0x12 and rw=1 -> rd_en=16'h0004 at N+1; tx_d=0x5C and tx_en=1 at N+2.
- Write burst with AUTO_INC=1: addr 0x1E, bytes 0x01, 0x02, 0x03 -> wr_en bit14 then bit15, then no strobe for address 0x20 (unmapped); err_cnt=1.
- Read burst from 0x1F: first tx_d = ch15 data; dummy rxdv -> next tx_d = 0xEE; err_cnt=1. Then err_clr together with a new unmapped access -> err_cnt=0.
- Priority: addr_dv and rxdv in the same cycle during WR_WAIT -> no wr_en, address reloaded. txn_end followed by rxdv -> no strobe.
- Reset and saturation: assert reset_n=0 mid read burst -> all outputs 0 immediately. With ERR_W=2, 5 unmapped writes -> err_cnt=3.

Source files
------------

// File: rtl/reg_router_pkg.sv
// rtl/reg_router_pkg.sv - shared types, constants and helpers for reg_router
package reg_router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        RD_STROBE,
        RD_CAPTURE,
        RD_WAIT
    } state_t;

    localparam logic [7:0] UNMAPPED_VAL_DEF = 8'hEE;

    // Channel offset of an address relative to the window base.
    function automatic logic [31:0] ch_index(input logic [31:0] addr, input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/reg_router_dec.sv
// rtl/reg_router_dec.sv - combinational window decode of a register address
//
// Ports:
//   addr   - register address to decode
//   mapped - 1 when addr lies in [BASE_ADDR, BASE_ADDR+NUM_CH)
//   ch     - channel index (addr - BASE_ADDR), valid only when mapped
module reg_router_dec
    import reg_router_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int BASE_ADDR = 0,
    parameter int NUM_CH    = 16
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              mapped,
    output logic [ADDR_W-1:0] ch
);

    // One extra bit so NUM_CH == 2**ADDR_W and the subtraction cannot wrap.
    localparam int EW = ADDR_W + 1;
    localparam logic [EW-1:0] BASE_X = EW'(BASE_ADDR);
    localparam logic [EW-1:0] NUM_X  = EW'(NUM_CH);

    logic [EW-1:0] addr_x;
    logic [EW-1:0] diff;

    always_comb begin
        addr_x = {1'b0, addr};
        diff   = EW'(ch_index(32'(addr_x), 32'(BASE_X)));
        mapped = (addr_x >= BASE_X) && (diff < NUM_X);
        ch     = diff[ADDR_W-1:0];
    end

endmodule

// File: rtl/reg_router.sv
// rtl/reg_router.sv - routes spi_slave register accesses onto NUM_CH peripheral channels
//
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   reg_addr, addr_dv, rw_out - frame address/direction from spi_slave
//   rx_d, rxdv              - received data byte
//   txn_end                 - end of SPI frame
//   tx_d, tx_en             - read data returned to spi_slave
//   wr_en, rd_en            - one-hot per-channel strobes
//   data_to_periph          - shared write data
//   data_from_periph        - packed per-channel read data
//   err_cnt, err_clr        - saturating unmapped-access counter and its clear
module reg_router
    import reg_router_pkg::*;
#(
    parameter int                ADDR_W       = 7,
    parameter int                DATA_W       = 8,
    parameter int                NUM_CH       = 16,
    parameter int                BASE_ADDR    = 0,
    parameter int                AUTO_INC     = 1,
    parameter logic [DATA_W-1:0] UNMAPPED_VAL = DATA_W'(UNMAPPED_VAL_DEF),
    parameter int                ERR_W        = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        reg_addr,
    input  logic                     addr_dv,
    input  logic                     rw_out,
    input  logic [DATA_W-1:0]        rx_d,
    input  logic                     rxdv,
    input  logic                     txn_end,
    output logic [DATA_W-1:0]        tx_d,
    output logic                     tx_en,
    output logic [NUM_CH-1:0]        wr_en,
    output logic [NUM_CH-1:0]        rd_en,
    output logic [DATA_W-1:0]        data_to_periph,
    input  logic [NUM_CH*DATA_W-1:0] data_from_periph,
    output logic [ERR_W-1:0]         err_cnt,
    input  logic                     err_clr
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic              wr_go, rd_go, cap_go, err_ev;
    logic              q_mapped, d_mapped;
    logic [ADDR_W-1:0] q_ch, d_ch;
    logic [DATA_W-1:0] rd_data;

    // Current address: write strobes and read capture.
    reg_router_dec #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .NUM_CH(NUM_CH)) u_dec_q (
        .addr   (addr_q),
        .mapped (q_mapped),
        .ch     (q_ch)
    );

    // Next address: the read strobe is registered on the same edge that loads it.
    reg_router_dec #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .NUM_CH(NUM_CH)) u_dec_d (
        .addr   (addr_d),
        .mapped (d_mapped),
        .ch     (d_ch)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wr_go   = 1'b0;
        rd_go   = 1'b0;
        cap_go  = 1'b0;
        if (addr_dv) begin
            // New frame address wins; a coincident rxdv is dropped.
            addr_d  = reg_addr;
            rw_d    = rw_out;
            rd_go   = rw_out;
            state_d = rw_out ? RD_STROBE : WR_WAIT;
        end else if (txn_end) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                WR_WAIT: begin
                    if (rxdv) begin
                        wr_go = 1'b1;
                        if (AUTO_INC != 0) addr_d = addr_q + ADDR_W'(1);
                    end
                end
                RD_STROBE: begin
                    cap_go  = 1'b1;
                    state_d = RD_CAPTURE;
                end
                RD_CAPTURE: state_d = RD_WAIT;
                RD_WAIT: begin
                    if (rxdv) begin
                        rd_go   = 1'b1;
                        state_d = RD_STROBE;
                        if (AUTO_INC != 0) addr_d = addr_q + ADDR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        err_ev  = (wr_go && !q_mapped) || (rd_go && !d_mapped);
        rd_data = q_mapped ? data_from_periph[int'(q_ch)*DATA_W +: DATA_W] : UNMAPPED_VAL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            rw_q           <= 1'b0;
            tx_d           <= '0;
            tx_en          <= 1'b0;
            wr_en          <= '0;
            rd_en          <= '0;
            data_to_periph <= '0;
            err_cnt        <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wr_en   <= (wr_go && q_mapped) ? (NUM_CH'(1) << q_ch) : '0;
            rd_en   <= (rd_go && d_mapped) ? (NUM_CH'(1) << d_ch) : '0;
            if (wr_go && q_mapped) data_to_periph <= rx_d;
            tx_en <= cap_go;
            if (cap_go) tx_d <= rd_data;
            if (err_clr)
                err_cnt <= '0;
            else if (err_ev && (err_cnt != '1))
                err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule
